// File: rtl/t_using_d_counter_if.sv
// Control/status bundle for the T-from-D modulo counter. The master drives the
// count controls; the slave returns the count, its toggle excitation and events.
interface t_using_d_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  q, t_vec, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, t_vec, tc, wrap
  );
endinterface

// File: rtl/t_using_d_counter.sv
// Modulo-N up/down counter whose bits are T flops built from D flops (D = T ^ Q); q updates one edge
// after sampling, tc/t_vec are same-cycle. T_USING_D_SATURATE_EN selects saturation instead of wrapping.
module t_using_d_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 10
) (
  input  logic               clk,
  input  logic               rst,
  t_using_d_counter_if.slave bus
);

  if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
    $fatal(1, "t_using_d_counter: WIDTH %0d outside 2..16", WIDTH);
  end
  if ((MOD_VALUE < 2) || (MOD_VALUE > (1 << WIDTH))) begin : g_bad_mod
    $fatal(1, "t_using_d_counter: MOD_VALUE %0d outside 2..2**WIDTH", MOD_VALUE);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_VALUE - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t_vec;
  logic             wrap_q;
  logic             wrap_d;

  // Target value of the count; only used to derive the toggle excitation.
  always_comb begin
    next_q = q_q;
    wrap_d = 1'b0;
    if (rst) begin
      next_q = '0;
    end else if (bus.load) begin
      next_q = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (q_q >= MAX_Q) begin
`ifdef T_USING_D_SATURATE_EN
          next_q = (q_q == MAX_Q) ? q_q : '0;
`else
          next_q = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          next_q = q_q + WIDTH'(1);
        end
      end else begin
        if ((q_q == '0) || (q_q > MAX_Q)) begin
`ifdef T_USING_D_SATURATE_EN
          next_q = (q_q == '0) ? q_q : MAX_Q;
`else
          next_q = MAX_Q;
          wrap_d = 1'b1;
`endif
        end else begin
          next_q = q_q - WIDTH'(1);
        end
      end
    end
  end

  assign t_vec = next_q ^ q_q;
  assign q_d   = t_vec ^ q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.t_vec = t_vec;
  assign bus.tc    = bus.up_dn ? (q_q == MAX_Q) : (q_q == '0);
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/t_using_d_counter.md
Name: t_using_d_counter

Overview:
- Synchronous modulo-N up/down counter whose bits are T flip-flops built from D flip-flops. Each bit register is loaded with D = T ^ Q, which is the inverse of the D-from-T conversion.
- Supplies counting and terminal-count events to sequential blocks in the flip-flop conversion library.
- Exposes the per-bit toggle excitation vector so benches can check the T-excitation equations directly.

Parameters:
- WIDTH, 4, counter bit width; legal range 2..16.
- MOD_VALUE, 10, count modulus; the count runs 0..MOD_VALUE-1. Legal range 2..2**WIDTH, checked at elaboration; an illegal value is a fatal error.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high, sampled on rising clk.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- t_vec  output  WIDTH  combinational toggle excitation applied at the next edge (bit i = 1 means q[i] toggles).
- tc  output  1  combinational terminal count: q==MOD_VALUE-1 when up_dn=1, q==0 when up_dn=0; independent of en.
- wrap  output  1  registered one-cycle pulse; high in the cycle after a wrap occurred.

Behaviour:
- Reset: one clock, one synchronous active-high reset. While rst=1 at a rising edge: q <= 0, wrap <= 0. Reset overrides load and en. Reset mid-count discards the count immediately.
- Register structure:
  - Every q bit is a D register with D[i] = t_vec[i] ^ q[i].
  - t_vec = next_q ^ q, computed combinationally.
  - Every q update goes through the toggle path, including load.
- Priority at each edge: rst > load > en > hold.
- Load:
  - next_q = load_val when load_val <= MOD_VALUE-1.
  - Otherwise next_q = MOD_VALUE-1 (clamp).
  - wrap <= 0 on a load edge. Load ignores en and up_dn.
- Count up (en=1, up_dn=1): next_q = q+1. At q==MOD_VALUE-1, next_q = 0 and wrap <= 1.
- Count down (en=1, up_dn=0): next_q = q-1. At q==0, next_q = MOD_VALUE-1 and wrap <= 1.
- Hold (en=0, no load): next_q = q, t_vec = 0, wrap <= 0.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (MOD_VALUE=2, or alternating direction at the boundary) produce wrap high on consecutive cycles.
- Out-of-range state: if q ever holds a value >= MOD_VALUE, the next enabled count goes to 0 (up) or MOD_VALUE-1 (down), and wrap <= 1. This state is unreachable from reset or load.
- Latency:
  - q changes one edge after load/en sampling.
  - tc and t_vec respond combinationally within the same cycle.
- Arithmetic:
  - All arithmetic is WIDTH bits, unsigned.
  - When MOD_VALUE == 2**WIDTH, wrap-around is the natural overflow and the wrap pulse still fires.
- Changing up_dn mid-run takes effect at the next edge; no extra latency.

Optional Feature:
- Macro: T_USING_D_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping.
  - Counting up at MOD_VALUE-1, or down at 0, holds q and forces t_vec = 0.
  - wrap is tied to 0.
  - tc is unchanged and stays high while saturated.
  - Load clamping is unchanged.
- Not defined: wrap behaviour exactly as in Behaviour.
- The port list is identical in both builds.

Test Plan (WIDTH=4, MOD_VALUE=10 unless noted):
- Reset/hold/load priority:
  - Stimulus: rst=1 with load=1, load_val=5, en=1 for one edge; then rst=0, en=0 for 3 edges.
  - Required: q=0 after the reset edge, q stays 0 for the 3 hold edges, wrap=0, t_vec=0 throughout.
- Up count and wrap:
  - Stimulus: en=1, up_dn=1 for 12 edges from 0.
  - Required:
    - q sequence 1..9, 0, 1, 2.
    - tc=1 only while q=9.
    - wrap=1 only in the cycle q=0 follows 9.
    - t_vec=4'b1001 when q=9.
- Down count and wrap:
  - Stimulus: load 2, then en=1, up_dn=0 for 4 edges.
  - Required: q = 2, 1, 0, 9, 8; wrap=1 only in the cycle q=9 follows 0; t_vec=4'b1001 when q=0.
- Load clamp and load-over-enable:
  - Stimulus: load=1, load_val=13, en=1, up_dn=1.
  - Required: q=9 (not 10 or 0), wrap=0; the next enabled up edge gives q=0, wrap=1.
- Reset mid-operation and direction change:
  - Stimulus: count to 6; assert rst for one edge while en=1; then run up 2 edges, flip to up_dn=0 for 1 edge.
  - Required: q = 6, 0, 1, 2, 1; no wrap pulse.
- Saturate build (T_USING_D_SATURATE_EN defined):
  - Stimulus: load 8, en=1, up_dn=1 for 3 edges; then up_dn=0 from load 0 for 2 edges.
  - Required:
    - Up phase: q = 9, 9, 9 with t_vec=0 at 9.
    - Down phase: q = 0, 0.
    - wrap=0 throughout; tc=1 while saturated.
